// File: rtl/punc_control.sv
// -----------------------------------------------------------------------------
// punc_control
//
// Control unit for the PUnC LC3 processor. It steps the datapath through
// fetch, decode and execute for the supported LC3 subset, and it owns the
// N/Z/P condition-code register.
//
// Configuration macro:
//   PUNC_INDIRECT_EN - when defined, LDI/STI execute through EXEC2 and use
//                      mar_ld. When undefined, opcodes 1010/1011 decode to
//                      HALT and mar_ld is tied to 0.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   ir[15:0]       in   instruction register contents
//   rf_w_data[15:0]in   register-file write data, sampled for condition codes
//   ir_ld          out  load IR from the memory read port
//   pc_clr/inc/ld  out  PC clear / increment / load
//   pc_ld_sel[1:0] out  0 PC+off9, 1 PC+off11, 2 R[ir[8:6]]
//   mem_addr_sel   out  0 PC, 1 PC+off9, 2 R[ir[8:6]]+off6, 3 MAR
//   mem_w_en       out  memory write enable
//   mar_ld         out  latch memory read data into MAR
//   rf_w_en        out  register-file write enable
//   rf_w_addr_sel  out  0 ir[11:9], 1 R7
//   rf_w_data_sel  out  0 ALU, 1 memory, 2 PC+off9, 3 PC
//   rf_r0_addr_sel out  0 ir[8:6], 1 ir[11:9]
//   alu_sel[1:0]   out  0 ADD, 1 AND, 2 NOT, 3 PASS
//   alu_imm        out  ALU operand B is sext(ir[4:0])
//   nzp[2:0]       out  current condition codes
//   halted         out  core is stopped
// -----------------------------------------------------------------------------
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [15:0] rf_w_data,
  output logic        ir_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [1:0]  pc_ld_sel,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic        mar_ld,
  output logic        rf_w_en,
  output logic        rf_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_r0_addr_sel,
  output logic [1:0]  alu_sel,
  output logic        alu_imm,
  output logic [2:0]  nzp,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_EXEC2,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t      state_q, state_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [3:0]  opcode;
  logic        br_taken;
  logic        sets_cc;

  // Offset and base-register fields are consumed by the datapath, not here.
  logic        unused_ir_bits;
  assign unused_ir_bits = ^{ir[8:6], ir[4:0]};

  assign opcode   = ir[15:12];
  assign br_taken = |(ir[11:9] & nzp_q);
  assign nzp      = nzp_q;

  // Opcodes whose register write updates the condition codes. JSR/JSRR
  // writes R7 but is deliberately excluded.
  always_comb begin
    sets_cc = 1'b0;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: sets_cc = 1'b1;
      default:                                               sets_cc = 1'b0;
    endcase
  end

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == '0)   return 3'b010;
    else                return 3'b001;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      nzp_q   <= 3'b010;
    end else begin
      state_q <= state_d;
      nzp_q   <= nzp_d;
    end
  end

  // rf_w_en is already forced low during rst, so this never fires then.
  always_comb begin
    nzp_d = nzp_q;
    if (rf_w_en && sets_cc) nzp_d = cc_of(rf_w_data);
  end

  always_comb begin
    state_d        = state_q;
    ir_ld          = 1'b0;
    pc_clr         = 1'b0;
    pc_inc         = 1'b0;
    pc_ld          = 1'b0;
    pc_ld_sel      = 2'd0;
    mem_addr_sel   = 2'd0;
    mem_w_en       = 1'b0;
    mar_ld         = 1'b0;
    rf_w_en        = 1'b0;
    rf_w_addr_sel  = 1'b0;
    rf_w_data_sel  = 2'd0;
    rf_r0_addr_sel = 1'b0;
    alu_sel        = 2'd0;
    alu_imm        = 1'b0;
    halted         = 1'b0;

    if (rst) begin
      // Abort whatever was in flight: only the PC clear is allowed through.
      pc_clr  = 1'b1;
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_INIT: begin
          pc_clr  = 1'b1;
          state_d = S_FETCH;
        end

        S_FETCH: begin
          mem_addr_sel = 2'd0;
          ir_ld        = 1'b1;
          pc_inc       = 1'b1;
          state_d      = S_DECODE;
        end

        S_DECODE: begin
          case (opcode)
            OP_TRAP, OP_RTI, OP_RSV: state_d = S_HALT;
            OP_BR:                   state_d = br_taken ? S_EXEC : S_FETCH;
`ifndef PUNC_INDIRECT_EN
            OP_LDI, OP_STI:          state_d = S_HALT;
`endif
            default:                 state_d = S_EXEC;
          endcase
        end

        S_EXEC: begin
          state_d = S_FETCH;
          case (opcode)
            OP_ADD: begin
              rf_w_en = 1'b1;
              alu_sel = 2'd0;
              alu_imm = ir[5];
            end
            OP_AND: begin
              rf_w_en = 1'b1;
              alu_sel = 2'd1;
              alu_imm = ir[5];
            end
            OP_NOT: begin
              rf_w_en = 1'b1;
              alu_sel = 2'd2;
            end
            OP_LD: begin
              mem_addr_sel  = 2'd1;
              rf_w_data_sel = 2'd1;
              rf_w_en       = 1'b1;
            end
            OP_LDR: begin
              mem_addr_sel  = 2'd2;
              rf_w_data_sel = 2'd1;
              rf_w_en       = 1'b1;
            end
            OP_LEA: begin
              rf_w_data_sel = 2'd2;
              rf_w_en       = 1'b1;
            end
            OP_ST: begin
              mem_addr_sel   = 2'd1;
              rf_r0_addr_sel = 1'b1;
              mem_w_en       = 1'b1;
            end
            OP_STR: begin
              mem_addr_sel   = 2'd2;
              rf_r0_addr_sel = 1'b1;
              mem_w_en       = 1'b1;
            end
            // Only taken branches reach EXEC; nzp cannot change in between.
            OP_BR: begin
              pc_ld     = 1'b1;
              pc_ld_sel = 2'd0;
            end
            OP_JMP: begin
              pc_ld     = 1'b1;
              pc_ld_sel = 2'd2;
            end
            // R7 <= PC and PC <= target share one edge, so JSRR R7 reads
            // the old R7 as its base before the write lands.
            OP_JSR: begin
              rf_w_en       = 1'b1;
              rf_w_addr_sel = 1'b1;
              rf_w_data_sel = 2'd3;
              pc_ld         = 1'b1;
              pc_ld_sel     = ir[11] ? 2'd1 : 2'd2;
            end
`ifdef PUNC_INDIRECT_EN
            // First access fetches the pointer into MAR.
            OP_LDI, OP_STI: begin
              mem_addr_sel = 2'd1;
              mar_ld       = 1'b1;
              state_d      = S_EXEC2;
            end
`endif
            default: state_d = S_FETCH;
          endcase
        end

        S_EXEC2: begin
          state_d = S_FETCH;
`ifdef PUNC_INDIRECT_EN
          mem_addr_sel = 2'd3;
          if (opcode == OP_LDI) begin
            rf_w_data_sel = 2'd1;
            rf_w_en       = 1'b1;
          end else if (opcode == OP_STI) begin
            rf_r0_addr_sel = 1'b1;
            mem_w_en       = 1'b1;
          end
`endif
        end

        S_HALT: begin
          halted  = 1'b1;
          state_d = S_HALT;
        end

        default: state_d = S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control.sv
module tb_punc_control;

  logic        clk;
  logic        rst;
  logic [15:0] ir;
  logic [15:0] rf_w_data;
  logic        ir_ld, pc_clr, pc_inc, pc_ld;
  logic [1:0]  pc_ld_sel, mem_addr_sel;
  logic        mem_w_en, mar_ld, rf_w_en, rf_w_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_r0_addr_sel;
  logic [1:0]  alu_sel;
  logic        alu_imm;
  logic [2:0]  nzp;
  logic        halted;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_ld_sel;
    logic [1:0] mem_addr_sel;
    logic       mem_w_en;
    logic       mar_ld;
    logic       rf_w_en;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_r0_addr_sel;
    logic [1:0] alu_sel;
    logic       alu_imm;
    logic       halted;
  } ctl_t;

  ctl_t obs;
  assign obs = {ir_ld, pc_clr, pc_inc, pc_ld, pc_ld_sel, mem_addr_sel,
                mem_w_en, mar_ld, rf_w_en, rf_w_addr_sel, rf_w_data_sel,
                rf_r0_addr_sel, alu_sel, alu_imm, halted};

  int checks = 0;
  int errors = 0;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .rf_w_data(rf_w_data),
    .ir_ld(ir_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .pc_ld_sel(pc_ld_sel), .mem_addr_sel(mem_addr_sel), .mem_w_en(mem_w_en),
    .mar_ld(mar_ld), .rf_w_en(rf_w_en), .rf_w_addr_sel(rf_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_r0_addr_sel(rf_r0_addr_sel),
    .alu_sel(alu_sel), .alu_imm(alu_imm), .nzp(nzp), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam ctl_t V_IDLE  = '0;
  localparam ctl_t V_CLR   = '{pc_clr: 1'b1, default: '0};
  localparam ctl_t V_FETCH = '{ir_ld: 1'b1, pc_inc: 1'b1, default: '0};
  localparam ctl_t V_HALT  = '{halted: 1'b1, default: '0};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  // FETCH and DECODE of one instruction; nzp is checked at FETCH, which
  // reflects the previous instruction's register write.
  task automatic fd(input logic [15:0] op, input logic [2:0] exp_nzp, input string tag);
    step();
    ir = op;
    #1;
    chk({tag, " fetch"}, obs, V_FETCH);
    chk({tag, " nzp"}, {29'd0, nzp}, {29'd0, exp_nzp});
    step();
    #1;
    chk({tag, " decode"}, obs, V_IDLE);
  endtask

  task automatic ex(input ctl_t e, input logic [15:0] wd, input string tag);
    step();
    rf_w_data = wd;
    #1;
    chk({tag, " exec"}, obs, e);
  endtask

  initial begin
    rst = 1'b1;
    ir = 16'h0000;
    rf_w_data = 16'h0000;

    // Reset, then the INIT cycle.
    step();
    #1;
    chk("rst outputs", obs, V_CLR);
    chk("rst nzp", {29'd0, nzp}, 32'd2);
    rst = 1'b0;
    #1;
    chk("init", obs, V_CLR);

    // ADD R1,R1,#1 -> positive result.
    fd(16'h1261, 3'b010, "add");
    ex('{rf_w_en: 1'b1, alu_imm: 1'b1, default: '0}, 16'h0001, "add");

    // AND R1,R1,#0 -> zero result.
    fd(16'h5260, 3'b001, "and");
    ex('{rf_w_en: 1'b1, alu_sel: 2'd1, alu_imm: 1'b1, default: '0}, 16'h0000, "and");

    // BRnp with nzp=010: not taken, back to FETCH after DECODE.
    fd(16'h0A05, 3'b010, "brnp");

    // BRz: taken.
    fd(16'h0405, 3'b010, "brz");
    ex('{pc_ld: 1'b1, default: '0}, 16'h0000, "brz");

    // JSR: R7 write with negative data must not touch nzp.
    fd(16'h4803, 3'b010, "jsr");
    ex('{rf_w_en: 1'b1, rf_w_addr_sel: 1'b1, rf_w_data_sel: 2'd3, pc_ld: 1'b1,
         pc_ld_sel: 2'd1, default: '0}, 16'h8000, "jsr");

    fd(16'h2205, 3'b010, "ld");
    ex('{mem_addr_sel: 2'd1, rf_w_data_sel: 2'd1, rf_w_en: 1'b1, default: '0}, 16'h1234, "ld");

    fd(16'h6245, 3'b001, "ldr");
    ex('{mem_addr_sel: 2'd2, rf_w_data_sel: 2'd1, rf_w_en: 1'b1, default: '0}, 16'h8001, "ldr");

    fd(16'hE205, 3'b100, "lea");
    ex('{rf_w_data_sel: 2'd2, rf_w_en: 1'b1, default: '0}, 16'h0000, "lea");

    fd(16'h7245, 3'b010, "str");
    ex('{mem_addr_sel: 2'd2, rf_r0_addr_sel: 1'b1, mem_w_en: 1'b1, default: '0}, 16'h0001, "str");

    // NOT with ir[5]=1 must still keep alu_imm low.
    fd(16'h927F, 3'b010, "not");
    ex('{rf_w_en: 1'b1, alu_sel: 2'd2, default: '0}, 16'h8000, "not");

    fd(16'hC1C0, 3'b100, "jmp");
    ex('{pc_ld: 1'b1, pc_ld_sel: 2'd2, default: '0}, 16'h0000, "jmp");

`ifdef PUNC_INDIRECT_EN
    fd(16'hA405, 3'b100, "ldi");
    ex('{mem_addr_sel: 2'd1, mar_ld: 1'b1, default: '0}, 16'h0001, "ldi");
    ex('{mem_addr_sel: 2'd3, rf_w_data_sel: 2'd1, rf_w_en: 1'b1, default: '0}, 16'h0000, "ldi2");

    fd(16'hB405, 3'b010, "sti");
    ex('{mem_addr_sel: 2'd1, mar_ld: 1'b1, default: '0}, 16'h8000, "sti");
    ex('{mem_addr_sel: 2'd3, rf_r0_addr_sel: 1'b1, mem_w_en: 1'b1, default: '0}, 16'h8000, "sti2");
    fd(16'h0000, 3'b010, "post sti");
`else
    // Without indirect support LDI stops the core.
    fd(16'hA405, 3'b100, "ldi");
    step();
    #1;
    chk("ldi halt", obs, V_HALT);
    step();
    rst = 1'b1;
    #1;
    chk("ldi rst", obs, V_CLR);
    step();
    rst = 1'b0;
    #1;
    chk("ldi init", obs, V_CLR);
`endif

    // rst during EXEC of ST aborts the store and returns to INIT.
    fd(16'h3205, 3'b010, "st");
    ex('{mem_addr_sel: 2'd1, rf_r0_addr_sel: 1'b1, mem_w_en: 1'b1, default: '0}, 16'h0000, "st");
    rst = 1'b1;
    #1;
    chk("st rst", obs, V_CLR);
    step();
    rst = 1'b0;
    #1;
    chk("st init", obs, V_CLR);

    // HALT: held for 20 cycles, then released only by rst.
    fd(16'hF025, 3'b010, "trap");
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      chk("halt hold", obs, V_HALT);
    end
    step();
    rst = 1'b1;
    #1;
    chk("halt rst", obs, V_CLR);
    step();
    rst = 1'b0;
    #1;
    chk("halt init", obs, V_CLR);
    fd(16'h1261, 3'b010, "after halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/punc_control.md
# punc_control

Control unit for the PUnC LC3 processor. It sequences the PUnC datapath through fetch, decode and execute for the supported LC3 subset, and owns the N/Z/P condition-code register. Its inputs are `ir` and the register-file write data. It drives every datapath enable and select, and it sits beside the datapath inside the PUnC top level.

## Interface
Parameters: none.

- `clk` input 1: system clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `ir` input 16: instruction register contents from the datapath.
- `rf_w_data` input 16: value the datapath is writing to the register file; sampled for condition codes.
- `ir_ld` output 1: load IR from the memory read port.
- `pc_clr`, `pc_inc`, `pc_ld` output 1 each: PC clear, increment, load.
- `pc_ld_sel` output 2: PC load source. 0 = PC+sext(ir[8:0]), 1 = PC+sext(ir[10:0]), 2 = R[ir[8:6]].
- `mem_addr_sel` output 2: memory address for read and write. 0 = PC, 1 = PC+sext(ir[8:0]), 2 = R[ir[8:6]]+sext(ir[5:0]), 3 = MAR.
- `mem_w_en` output 1: memory write enable.
- `mar_ld` output 1: latch the memory read data into the datapath MAR.
- `rf_w_en` output 1: register-file write enable.
- `rf_w_addr_sel` output 1: write address. 0 = ir[11:9], 1 = R7.
- `rf_w_data_sel` output 2: write data. 0 = ALU, 1 = memory, 2 = PC+sext(ir[8:0]), 3 = PC.
- `rf_r0_addr_sel` output 1: read port 0 address. 0 = ir[8:6], 1 = ir[11:9] (store source).
- `alu_sel` output 2: 0 = ADD, 1 = AND, 2 = NOT, 3 = PASS.
- `alu_imm` output 1: ALU operand B is sext(ir[4:0]). It equals ir[5] for ADD/AND and is 0 otherwise.
- `nzp` output 3: current condition codes.
- `halted` output 1: core is stopped.

## Operation
States are INIT, FETCH, DECODE, EXEC, EXEC2 and HALT. All outputs are combinational from the state and `ir`. Any output not listed for a state is 0.

- **rst:** the state goes to INIT and `nzp` goes to 3'b010. While `rst`=1, all outputs are 0 except `pc_clr`=1.
- **INIT:** `pc_clr`=1, then go to FETCH.
- **FETCH:** `mem_addr_sel`=0, `ir_ld`=1, `pc_inc`=1, then go to DECODE.
- **DECODE:** no enables. Next state by ir[15:12]:
  - 1111 (TRAP, any vector), 1000 and 1101 go to HALT.
  - 0000 BR with ir[11:9]&nzp==0 goes to FETCH (not taken).
  - Everything else goes to EXEC.
- **EXEC, per opcode:**
  - ADD 0001: `rf_w_en`, `alu_sel`=0.
  - AND 0101: `rf_w_en`, `alu_sel`=1.
  - NOT 1001: `rf_w_en`, `alu_sel`=2.
  - LD 0010: `mem_addr_sel`=1, `rf_w_data_sel`=1, `rf_w_en`.
  - LDR 0110: `mem_addr_sel`=2, `rf_w_data_sel`=1, `rf_w_en`.
  - LEA 1110: `rf_w_data_sel`=2, `rf_w_en`.
  - ST 0011: `mem_addr_sel`=1, `rf_r0_addr_sel`=1, `mem_w_en`.
  - STR 0111: `mem_addr_sel`=2, `rf_r0_addr_sel`=1, `mem_w_en`.
  - BR taken: `pc_ld`, `pc_ld_sel`=0.
  - JMP/RET 1100: `pc_ld`, `pc_ld_sel`=2.
  - JSR/JSRR 0100: `rf_w_en`, `rf_w_addr_sel`=1, `rf_w_data_sel`=3, `pc_ld`. `pc_ld_sel` is 1 if ir[11]=1, else 2. The R7 write uses the pre-load PC, so the JSRR R7 base is read before it is overwritten.
  - LDI 1010 / STI 1011: `mem_addr_sel`=1, `mar_ld`, then go to EXEC2.
  - All other opcodes return to FETCH.
- **EXEC2 (indirect only):** `mem_addr_sel`=3.
  - LDI: `rf_w_data_sel`=1, `rf_w_en`.
  - STI: `rf_r0_addr_sel`=1, `mem_w_en`.
  - Then go to FETCH.
- **HALT:** `halted`=1, with no enables. The core stays in HALT until `rst`.
- **Condition codes:** on a clock edge with `rf_w_en`=1 and opcode ADD, AND, NOT, LD, LDR, LDI or LEA, `nzp` becomes:
  - 100 if `rf_w_data`[15]=1,
  - 010 if `rf_w_data`=0,
  - 001 otherwise.
  - JSR/JSRR writes to R7 do not update `nzp`.

## Timing
- **Latencies (FETCH to next FETCH):**
  - Not-taken BR: 2 cycles.
  - Most instructions: 3 cycles.
  - LDI/STI: 4 cycles.
- The first FETCH occurs 2 cycles after `rst` deasserts (rst cycle, then INIT).
- The memory read port is combinational. Writes to the register file, memory, PC, IR, MAR and `nzp` take effect at the edge that ends the asserting state.
- An EXEC that writes a register and then a branch decode in the next instruction sees the updated `nzp`.
- `rst` asserted in any state, including EXEC2 and HALT, aborts the instruction. No write enable is issued in the `rst` cycle.

## Configuration
- `PUNC_INDIRECT_EN` defined: LDI and STI execute as above, via EXEC2 and `mar_ld`.
- Not defined: opcodes 1010 and 1011 decode to HALT, EXEC2 is unreachable, and `mar_ld` is tied to 0.

## Test plan
- Reset, then `ir`=0x1261 (ADD R1,R1,#1): sequence INIT, FETCH, DECODE, EXEC with `rf_w_en`=1, `alu_imm`=1 and `alu_sel`=0. With `rf_w_data`=0x0001, `nzp` becomes 001.
- After `nzp`=010, `ir`=0x0A05 (BRnp): DECODE goes straight to FETCH and `pc_ld` never asserts. `ir`=0x0405 (BRz): EXEC asserts `pc_ld`=1 with `pc_ld_sel`=0.
- `ir`=0x4803 (JSR): EXEC asserts `rf_w_addr_sel`=1, `rf_w_data_sel`=3 and `pc_ld_sel`=1, and `nzp` does not change.
- `ir`=0xA405 (LDI), with the macro defined: EXEC asserts `mar_ld`=1; EXEC2 asserts `mem_addr_sel`=3 and `rf_w_en`=1; 4 cycles from FETCH to FETCH. With the macro undefined: `halted`=1 after DECODE.
- `ir`=0xF025 (HALT): `halted`=1 from the cycle after DECODE and held for 20 cycles. Then `rst` pulsed: `halted`=0, with `pc_clr`=1 during the rst and INIT cycles.
- `rst` asserted during EXEC of ST 0x3205: `mem_w_en`=0 in that cycle, and the next state is INIT.
